mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive D-side grants allowed while an I-side request waits.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: i_req  in  1  fetch request strobe (single-cycle pulse).
REQ-005 Port: i_addr  in  32  fetch address.
REQ-006 Port: i_ack  out  1  fetch completion.
REQ-007 Port: i_rdata  out  32  fetched instruction.
REQ-008 Port: d_req  in  1  load/store request strobe (single-cycle pulse).
REQ-009 Port: d_we  in  1  1 = store, 0 = load.
REQ-010 Port: d_addr  in  32  data address.
REQ-011 Port: d_wdata  in  32  store data.
REQ-012 Port: d_ack  out  1  data completion.
REQ-013 Port: d_rdata  out  32  load data.
REQ-014 Port: c_req  out  1  cache request strobe.
REQ-015 Port: c_we, c_addr, c_wdata  out  1/32/32  cache command.
REQ-016 Port: c_ack  in  1  cache completion, same cycle as c_req on hit, later on miss.
REQ-017 Port: c_rdata  in  32  cache read data, valid with c_ack.

Function
REQ-018 One cache transaction outstanding at a time; states IDLE, BUSY_I, BUSY_D.
REQ-019 Each side has one pending slot (valid, addr; D also we, wdata); a req not issued in its arrival cycle is captured into its slot.
REQ-020 IDLE candidates per side: pending slot if valid, else live req; pending is issued before any new req from that side.
REQ-021 IDLE winner: D over I, except I wins when I is a candidate and starve_cnt == STARVE_LIMIT.
REQ-022 IDLE issue is combinational: c_req=1 and c_we/c_addr/c_wdata from winner in the same cycle; c_req low -> c_we=0, c_addr=0, c_wdata=0.
REQ-023 IDLE with c_ack in issue cycle: ack and c_rdata routed to winner same cycle; remain IDLE; winner slot cleared.
REQ-024 IDLE without c_ack: go BUSY_I/BUSY_D; winner command is held in an owner register; c_req deasserted while BUSY.
REQ-025 BUSY_x: c_ack -> x_ack=1, x_rdata=c_rdata that cycle, next IDLE; no issue in the ack cycle.
REQ-026 Losing and BUSY-arriving requests are captured, never dropped.
REQ-027 i_rdata/d_rdata are 0 whenever the corresponding ack is 0; at most one of i_ack/d_ack high per cycle.
REQ-028 starve_cnt (saturating at STARVE_LIMIT): +1 per D grant while I candidate or pending; cleared on I grant or when no I candidate/pending.
REQ-029 c_ack in IDLE with c_req=0 is ignored (no ack routed, no state change).
REQ-030 A req from a side whose slot is valid or whose transaction is outstanding is a protocol violation and is ignored.

Reset
REQ-031 rst (sync) -> state IDLE, both slots invalid, starve_cnt=0, owner cleared; all outputs 0 in the reset cycle.
REQ-032 rst mid-transaction abandons the transaction; a later stale c_ack is ignored per REQ-029.

Verification
REQ-033 Hit: i_req, i_addr=0x100, c_ack same cycle with c_rdata=0x00000013 -> c_addr=0x100, i_ack=1, i_rdata=0x13 same cycle, IDLE.
REQ-034 Collision: i_req 0x200 and d_req load 0x8000 same cycle, no c_ack -> c_addr=0x8000, BUSY_D; I captured; after d_ack, next cycle c_req=1 with c_addr=0x200.
REQ-035 Miss: d_req store 0x40/0xDEADBEEF, c_ack 3 cycles later -> c_we=1, c_wdata=0xDEADBEEF issue cycle; c_req=0 while BUSY; d_ack=1 exactly on the ack cycle.
REQ-036 Starvation: STARVE_LIMIT=2, I pending, d_req every IDLE cycle -> sequence D, D, I; starve_cnt cleared after I grant.
REQ-037 Reset mid-miss: BUSY_I, rst 1 cycle, then c_ack -> no i_ack, IDLE, slots empty.
REQ-038 Spurious c_ack in IDLE with no requests -> i_ack=d_ack=0, no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and cache-side signals of the I/D memory arbiter.
// The master modport is the requester/cache environment, and the slave modport is the arbiter.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_ack;
    logic [31:0] c_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_ack, c_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, c_req, c_we, c_addr, c_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_ack, c_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, c_req, c_we, c_addr, c_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto a single-outstanding cache port.
// D has priority over I. I wins after STARVE_LIMIT consecutive D grants while it waits.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned   CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state, state_nxt;

    logic          i_pend_v;
    logic [31:0]   i_pend_addr;
    logic          d_pend_v;
    logic          d_pend_we;
    logic [31:0]   d_pend_addr;
    logic [31:0]   d_pend_wdata;

    logic          own_we;
    logic [31:0]   own_addr;
    logic [31:0]   own_wdata;

    logic [CW-1:0] starve_cnt;

    logic          i_live, d_live;
    logic          i_wait, d_wait;
    logic          win_i, win_d, issue;
    logic          cmd_we;
    logic [31:0]   cmd_addr, cmd_wdata;

    always_comb begin
        state_nxt   = state;
        // A request from a side whose slot is full or whose transaction is in flight is ignored.
        i_live      = bus.i_req && !i_pend_v && (state != BUSY_I) && !rst;
        d_live      = bus.d_req && !d_pend_v && (state != BUSY_D) && !rst;
        i_wait      = i_pend_v || i_live;
        d_wait      = d_pend_v || d_live;
        win_i       = 1'b0;
        win_d       = 1'b0;
        issue       = 1'b0;
        cmd_we      = own_we;
        cmd_addr    = own_addr;
        cmd_wdata   = own_wdata;
        bus.i_ack   = 1'b0;
        bus.d_ack   = 1'b0;

        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (d_wait && !(i_wait && starve_cnt == LIMIT)) win_d = 1'b1;
                    else if (i_wait)                                win_i = 1'b1;
                    issue = win_i || win_d;
                    if (win_d) begin
                        cmd_we    = d_pend_v ? d_pend_we    : bus.d_we;
                        cmd_addr  = d_pend_v ? d_pend_addr  : bus.d_addr;
                        cmd_wdata = d_pend_v ? d_pend_wdata : bus.d_wdata;
                    end else if (win_i) begin
                        cmd_we    = 1'b0;
                        cmd_addr  = i_pend_v ? i_pend_addr : bus.i_addr;
                        cmd_wdata = '0;
                    end
                    if (issue) begin
                        if (bus.c_ack) begin
                            bus.i_ack = win_i;
                            bus.d_ack = win_d;
                        end else begin
                            state_nxt = win_i ? BUSY_I : BUSY_D;
                        end
                    end
                end
                BUSY_I: if (bus.c_ack) begin
                    bus.i_ack = 1'b1;
                    state_nxt = IDLE;
                end
                BUSY_D: if (bus.c_ack) begin
                    bus.d_ack = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // The owner copy feeds the command mux. c_req masks it whenever no issue is in progress.
        bus.c_req   = issue;
        bus.c_we    = issue && cmd_we;
        bus.c_addr  = issue ? cmd_addr  : '0;
        bus.c_wdata = issue ? cmd_wdata : '0;
        bus.i_rdata = bus.i_ack ? bus.c_rdata : '0;
        bus.d_rdata = bus.d_ack ? bus.c_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_pend_v     <= 1'b0;
            i_pend_addr  <= '0;
            d_pend_v     <= 1'b0;
            d_pend_we    <= 1'b0;
            d_pend_addr  <= '0;
            d_pend_wdata <= '0;
            own_we       <= 1'b0;
            own_addr     <= '0;
            own_wdata    <= '0;
            starve_cnt   <= '0;
        end else begin
            if (issue) begin
                own_we    <= cmd_we;
                own_addr  <= cmd_addr;
                own_wdata <= cmd_wdata;
            end

            if (win_i) begin
                i_pend_v <= 1'b0;
            end else if (i_live) begin
                i_pend_v    <= 1'b1;
                i_pend_addr <= bus.i_addr;
            end

            if (win_d) begin
                d_pend_v <= 1'b0;
            end else if (d_live) begin
                d_pend_v     <= 1'b1;
                d_pend_we    <= bus.d_we;
                d_pend_addr  <= bus.d_addr;
                d_pend_wdata <= bus.d_wdata;
            end

            if (win_i || !i_wait)                  starve_cnt <= '0;
            else if (win_d && starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Directed scenarios are followed by random traffic.
// A transaction-level reference model checks the traffic.
module tb_mem_arbiter;
    localparam int SL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_LIMIT(SL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;

    // Reference model: side in flight (0 none, 1 I, 2 D), pending requests and the starvation count.
    int          m_busy   = 0;
    bit          m_ip     = 0;
    logic [31:0] m_ia     = '0;
    bit          m_dp     = 0;
    bit          m_dwe    = 0;
    logic [31:0] m_da     = '0;
    logic [31:0] m_dw     = '0;
    int          m_starve = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic        e_creq, e_cwe, e_iack, e_dack;
        logic [31:0] e_caddr, e_cwdata, e_ird, e_drd;
        bit          i_new, d_new, i_has, d_has;
        int          pick;
        e_creq = 0; e_cwe = 0; e_iack = 0; e_dack = 0;
        e_caddr = '0; e_cwdata = '0; e_ird = '0; e_drd = '0;
        if (rst) begin
            m_busy = 0; m_ip = 0; m_dp = 0; m_starve = 0;
        end else begin
            i_new = bus.i_req && !m_ip && (m_busy != 1);
            d_new = bus.d_req && !m_dp && (m_busy != 2);
            if (m_busy == 0) begin
                i_has = m_ip || i_new;
                d_has = m_dp || d_new;
                pick = 0;
                if (d_has && !(i_has && m_starve == SL)) pick = 2;
                else if (i_has)                          pick = 1;
                if (pick == 2) begin
                    e_creq   = 1;
                    e_cwe    = m_dp ? m_dwe : bus.d_we;
                    e_caddr  = m_dp ? m_da  : bus.d_addr;
                    e_cwdata = m_dp ? m_dw  : bus.d_wdata;
                end else if (pick == 1) begin
                    e_creq  = 1;
                    e_caddr = m_ip ? m_ia : bus.i_addr;
                end
                if (pick == 2 && i_has) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                else                    m_starve = 0;
                if (pick != 0 && bus.c_ack) begin
                    if (pick == 1) begin e_iack = 1; e_ird = bus.c_rdata; end
                    else           begin e_dack = 1; e_drd = bus.c_rdata; end
                end else begin
                    m_busy = pick;
                end
                if (pick == 1)  m_ip = 0;
                else if (i_new) begin m_ip = 1; m_ia = bus.i_addr; end
                if (pick == 2)  m_dp = 0;
                else if (d_new) begin m_dp = 1; m_dwe = bus.d_we; m_da = bus.d_addr; m_dw = bus.d_wdata; end
            end else begin
                if (!(m_ip || i_new)) m_starve = 0;
                if (i_new) begin m_ip = 1; m_ia = bus.i_addr; end
                if (d_new) begin m_dp = 1; m_dwe = bus.d_we; m_da = bus.d_addr; m_dw = bus.d_wdata; end
                if (bus.c_ack) begin
                    if (m_busy == 1) begin e_iack = 1; e_ird = bus.c_rdata; end
                    else             begin e_dack = 1; e_drd = bus.c_rdata; end
                    m_busy = 0;
                end
            end
        end
        chk("c_req",   32'(bus.c_req), 32'(e_creq));
        chk("c_we",    32'(bus.c_we),  32'(e_cwe));
        chk("c_addr",  bus.c_addr,     e_caddr);
        chk("c_wdata", bus.c_wdata,    e_cwdata);
        chk("i_ack",   32'(bus.i_ack), 32'(e_iack));
        chk("i_rdata", bus.i_rdata,    e_ird);
        chk("d_ack",   32'(bus.d_ack), 32'(e_dack));
        chk("d_rdata", bus.d_rdata,    e_drd);
    endtask

    task automatic cyc(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd, input logic ca, input logic [31:0] cr);
        @(posedge clk);
        #1;
        rst = r;
        bus.i_req = ir; bus.i_addr = ia;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        bus.c_ack = ca; bus.c_rdata = cr;
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(input logic ca, input logic [31:0] cr);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, ca, cr);
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.c_ack = 0; bus.c_rdata = '0;

        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cyc(1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 32'h48, 32'h1, 1'b1, 32'h9);
        chk("rst_c_req", 32'(bus.c_req), 32'd0);
        chk("rst_i_ack", 32'(bus.i_ack), 32'd0);

        // Fetch that hits in the cache
        cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 1'b1, 32'h13);
        chk("hit_c_addr",  bus.c_addr,  32'h100);
        chk("hit_i_rdata", bus.i_rdata, 32'h13);

        // Stray c_ack while idle
        idle(1'b1, 32'hABCD);
        chk("spur_i_ack", 32'(bus.i_ack), 32'd0);
        chk("spur_d_ack", 32'(bus.d_ack), 32'd0);

        // Fetch and load arrive together; D goes first and I is issued after it
        cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h8000, '0, 1'b0, '0);
        chk("col_c_addr", bus.c_addr, 32'h8000);
        idle(1'b0, '0);
        idle(1'b1, 32'h55);
        chk("col_d_ack", 32'(bus.d_ack), 32'd1);
        idle(1'b0, '0);
        chk("col_i_issue", bus.c_addr, 32'h200);
        idle(1'b1, 32'h77);
        chk("col_i_rdata", bus.i_rdata, 32'h77);

        // Store that misses
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, '0);
        chk("miss_c_wdata", bus.c_wdata, 32'hDEADBEEF);
        for (int k = 0; k < 2; k++) begin
            idle(1'b0, '0);
            chk("miss_busy_c_req", 32'(bus.c_req), 32'd0);
        end
        idle(1'b1, 32'h0);
        chk("miss_d_ack", 32'(bus.d_ack), 32'd1);

        // I waits while D requests keep arriving; expected grant order is D, D, I
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h90, '0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        idle(1'b1, 32'h1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'hA0, '0, 1'b1, 32'h2);
        chk("starve_g1", bus.c_addr, 32'hA0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'hA4, '0, 1'b1, 32'h3);
        chk("starve_g2", bus.c_addr, 32'hA4);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'hA8, '0, 1'b1, 32'h4);
        chk("starve_g3_i", bus.c_addr, 32'h300);
        idle(1'b1, 32'h5);
        chk("starve_g4_d", bus.c_addr, 32'hA8);

        // Reset during a fetch miss; the late c_ack must be ignored
        cyc(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        idle(1'b1, 32'hBAD);
        chk("rstmid_i_ack", 32'(bus.i_ack), 32'd0);
        cyc(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 1'b1, 32'h6);
        chk("rstmid_after", bus.c_addr, 32'h500);

        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, $urandom,
                $urandom_range(0, 2) == 0, 1'($urandom), $urandom, $urandom,
                $urandom_range(0, 1) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
